// File: rtl/bcd_addsub_pkg.sv
// Shared types and helpers for the digit-serial BCD add/subtract unit.
// Holds digit width, BCD limit, FSM state encodings and digit validation.
package bcd_addsub_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t CALC = 2'd1;
   localparam state_t FIX  = 2'd2;
   localparam state_t DONE = 2'd3;

   function automatic logic is_bcd_digit(
      input logic [DIGIT_W-1:0] d
   );
      return d <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational one-digit BCD cell: s = x + (inv ? 9-y : y) + cin.
// Ports: x, y (BCD digits), cin, inv in; s (BCD digit), cout out.
module bcd_digit_addsub
   import bcd_addsub_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               cin,
   input  logic               inv,
   output logic [DIGIT_W-1:0] s,
   output logic               cout
);

   logic [DIGIT_W-1:0] y_eff;
   logic [DIGIT_W:0]   t;
   logic [DIGIT_W:0]   t_adj;

   always_comb begin
      y_eff = inv ? (BCD_MAX - y) : y;
      t     = {1'b0, x} + {1'b0, y_eff}
            + {{DIGIT_W{1'b0}}, cin};
      t_adj = t - (DIGIT_W+1)'(10);
      if (t > {1'b0, BCD_MAX}) begin
         s    = t_adj[DIGIT_W-1:0];
         cout = 1'b1;
      end else begin
         s    = t[DIGIT_W-1:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial BCD add/subtract, LSB digit first, sign-magnitude result.
// Ports: clk, rst_n, start, sub_sel, a, b in; busy, done, result, carry,
// neg, err out. Optional acc_sel input under BCD_ADDSUB_ACCUM_EN selects
// the stored result magnitude as operand A for chained calculation.
module bcd_addsub_seq
   import bcd_addsub_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    sub_sel,
`ifdef BCD_ADDSUB_ACCUM_EN
   input  logic                    acc_sel,
`endif
   input  logic [DIGIT_W*DIGITS-1:0] a,
   input  logic [DIGIT_W*DIGITS-1:0] b,
   output logic                    busy,
   output logic                    done,
   output logic [DIGIT_W*DIGITS-1:0] result,
   output logic                    carry,
   output logic                    neg,
   output logic                    err
);

   localparam int W  = DIGIT_W * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            sub_q;
   logic            c_q;

   logic [W-1:0]    op_a;
   logic            bad_in;
   logic            last;

   logic [DIGIT_W-1:0] a_dig;
   logic [DIGIT_W-1:0] b_dig;
   logic [DIGIT_W-1:0] r_dig;

   logic [DIGIT_W-1:0] cell_x;
   logic [DIGIT_W-1:0] cell_y;
   logic               cell_inv;
   logic [DIGIT_W-1:0] cell_s;
   logic               cell_cout;

`ifdef BCD_ADDSUB_ACCUM_EN
   // An error result is already 0, so it chains as 0.
   assign op_a = acc_sel ? result : a;
`else
   assign op_a = a;
`endif

   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_bcd_digit(op_a[i*DIGIT_W +: DIGIT_W]) ||
             !is_bcd_digit(b[i*DIGIT_W +: DIGIT_W]))
            bad_in = 1'b1;
      end
   end

   always_comb begin
      a_dig = '0;
      b_dig = '0;
      r_dig = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            a_dig = a_q[i*DIGIT_W +: DIGIT_W];
            b_dig = b_q[i*DIGIT_W +: DIGIT_W];
            r_dig = result[i*DIGIT_W +: DIGIT_W];
         end
      end
   end

   assign last = (idx == IW'(DIGITS-1));

   // FIX reuses the cell as 0 + (9 - r) + c, i.e. ten's complement.
   always_comb begin
      cell_x   = a_dig;
      cell_y   = b_dig;
      cell_inv = sub_q;
      if (state == FIX) begin
         cell_x   = '0;
         cell_y   = r_dig;
         cell_inv = 1'b1;
      end
   end

   bcd_digit_addsub u_cell (
      .x    (cell_x),
      .y    (cell_y),
      .cin  (c_q),
      .inv  (cell_inv),
      .s    (cell_s),
      .cout (cell_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         sub_q  <= 1'b0;
         c_q    <= 1'b0;
         result <= '0;
         carry  <= 1'b0;
         neg    <= 1'b0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q    <= op_a;
                  b_q    <= b;
                  sub_q  <= sub_sel;
                  c_q    <= sub_sel;
                  idx    <= '0;
                  result <= '0;
                  carry  <= 1'b0;
                  neg    <= 1'b0;
                  err    <= 1'b0;
                  if (bad_in) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               for (int i = 0; i < DIGITS; i++)
                  if (idx == IW'(i))
                     result[i*DIGIT_W +: DIGIT_W] <= cell_s;
               c_q <= cell_cout;
               idx <= idx + 1'b1;
               if (last) begin
                  idx <= '0;
                  if (!sub_q) begin
                     carry <= cell_cout;
                     state <= DONE;
                  end else if (cell_cout) begin
                     state <= DONE;
                  end else begin
                     // No end-around carry: difference is negative.
                     neg   <= 1'b1;
                     c_q   <= 1'b1;
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               for (int i = 0; i < DIGITS; i++)
                  if (idx == IW'(i))
                     result[i*DIGIT_W +: DIGIT_W] <= cell_s;
               c_q <= cell_cout;
               idx <= idx + 1'b1;
               if (last) begin
                  idx   <= '0;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Self-checking bench for bcd_addsub_seq with DIGITS=2.
// Table-driven vectors plus hand sequences for busy, reset and chaining.
module tb_bcd_addsub_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       sub_sel;
`ifdef BCD_ADDSUB_ACCUM_EN
   logic       acc_sel;
`endif
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       carry;
   logic       neg;
   logic       err;

   int checks;
   int failures;

   bcd_addsub_seq #(.DIGITS(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .sub_sel (sub_sel),
`ifdef BCD_ADDSUB_ACCUM_EN
      .acc_sel (acc_sel),
`endif
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .carry   (carry),
      .neg     (neg),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       cy;
      logic       ng;
      logic       er;
      int         lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
      end
   endtask

   // Issues one start, waits for done, returns latency in cycles.
   task automatic run_op(input logic s, input logic [7:0] av,
                         input logic [7:0] bv, input logic acc,
                         output int lat, output logic busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      @(negedge clk);
      start   = 1'b1;
      sub_sel = s;
      a       = av;
      b       = bv;
`ifdef BCD_ADDSUB_ACCUM_EN
      acc_sel = acc;
`else
      if (acc) $display("note: accumulate request ignored in this build");
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, int'(done), 0);
      check({tag, "_busy_drop"}, int'(busy), 0);
   endtask

   int   lat;
   logic bok;

   initial begin
      checks   = 0;
      failures = 0;
      start    = 1'b0;
      sub_sel  = 1'b0;
      a        = '0;
      b        = '0;
`ifdef BCD_ADDSUB_ACCUM_EN
      acc_sel  = 1'b0;
`endif
      rst_n    = 1'b0;

      vecs[0]  = '{1'b0, 8'h27, 8'h35, 8'h62, 1'b0, 1'b0, 1'b0, 3};
      vecs[1]  = '{1'b0, 8'h99, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 3};
      vecs[2]  = '{1'b1, 8'h42, 8'h17, 8'h25, 1'b0, 1'b0, 1'b0, 3};
      vecs[3]  = '{1'b1, 8'h17, 8'h42, 8'h25, 1'b0, 1'b1, 1'b0, 5};
      vecs[4]  = '{1'b0, 8'h1A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
      vecs[5]  = '{1'b1, 8'h42, 8'h42, 8'h00, 1'b0, 1'b0, 1'b0, 3};
      vecs[6]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3};
      vecs[7]  = '{1'b0, 8'h99, 8'h99, 8'h98, 1'b1, 1'b0, 1'b0, 3};
      vecs[8]  = '{1'b1, 8'h00, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 5};
      vecs[9]  = '{1'b1, 8'h05, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 1};
      vecs[10] = '{1'b1, 8'h50, 8'h49, 8'h01, 1'b0, 1'b0, 1'b0, 3};

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
      check("rst_flags", int'({carry, neg, err}), 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].sub, vecs[i].a, vecs[i].b, 1'b0, lat, bok);
         check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("v%0d_busy", i), int'(bok), 1);
         check($sformatf("v%0d_result", i), int'(result),
               int'(vecs[i].res));
         check($sformatf("v%0d_carry", i), int'(carry), int'(vecs[i].cy));
         check($sformatf("v%0d_neg", i), int'(neg), int'(vecs[i].ng));
         check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].er));
         after_done($sformatf("v%0d", i));
         check($sformatf("v%0d_hold", i), int'(result),
               int'(vecs[i].res));
      end

      // start while busy and start during the done cycle are ignored
      @(negedge clk);
      start   = 1'b1;
      sub_sel = 1'b0;
      a       = 8'h27;
      b       = 8'h35;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h11;
      b     = 8'h11;
      @(negedge clk);
      start = 1'b0;
      lat   = 2;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("busy_ign_lat", lat, 3);
      check("busy_ign_result", int'(result), 8'h62);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_ign_busy", int'(busy), 0);
      check("done_ign_result", int'(result), 8'h62);

      // reset in the middle of CALC aborts without a done pulse
      @(negedge clk);
      start   = 1'b1;
      sub_sel = 1'b0;
      a       = 8'h55;
      b       = 8'h55;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_result", int'(result), 0);
      check("abort_flags", int'({done, carry, neg, err}), 0);
      bok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done) bok = 1'b0;
      end
      check("abort_no_done", int'(bok), 1);
      rst_n = 1'b1;
      run_op(1'b0, 8'h55, 8'h55, 1'b0, lat, bok);
      check("restart_lat", lat, 3);
      check("restart_result", int'(result), 8'h10);
      check("restart_carry", int'(carry), 1);
      after_done("restart");

`ifdef BCD_ADDSUB_ACCUM_EN
      run_op(1'b0, 8'h27, 8'h35, 1'b0, lat, bok);
      check("acc_first", int'(result), 8'h62);
      run_op(1'b0, 8'h00, 8'h08, 1'b1, lat, bok);
      check("acc_chain", int'(result), 8'h70);
      check("acc_carry", int'(carry), 0);
      acc_sel = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
- Parametrised, digit-serial BCD add/subtract calculator; successor to the one-digit combinational add/sub unit.
- Processes DIGITS packed BCD digits, one digit per clock, LSB first.
- Reports sign-magnitude results for subtraction, flags carry and invalid-digit errors, and uses a start/busy/done handshake.
- Sits between the keypad/operand registers and the display driver of the calculator.

Parameters:
- DIGITS, 4, number of BCD digits per operand/result (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub_sel  input  1  0 = a+b, 1 = a−b; latched at start
- a  input  4*DIGITS  operand A, packed BCD, digit 0 at [3:0]
- b  input  4*DIGITS  operand B, packed BCD
- busy  output  1  high from cycle after accepted start until done cycle inclusive
- done  output  1  one-cycle pulse when result valid
- result  output  4*DIGITS  BCD magnitude of the result
- carry  output  1  addition overflow out of top digit
- neg  output  1  subtraction result negative
- err  output  1  an input digit was >9

Behaviour:
- Clock/reset: one clock domain (clk); reset asynchronous, active-low (rst_n).
- Reset: all outputs 0; FSM goes to IDLE; internal operand/carry registers 0. Reset asserted mid-operation aborts immediately; no done pulse.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches a, b, sub_sel, clears the digit index and sets busy next cycle.
  - If any digit of a or b is >9, go to DONE with result=0, err=1, carry=0, neg=0.
  - Otherwise go to CALC. Initial carry-in is sub_sel.
- CALC: one digit i per cycle, i = 0..DIGITS−1.
  - Compute t = a_i + (sub_sel ? 9−b_i : b_i) + c.
  - If t>9: r_i = t−10, c=1; else r_i = t, c=0.
  - After digit DIGITS−1:
    - add: carry = c, go to DONE.
    - sub with c=1: result non-negative, neg=0, go to DONE.
    - sub with c=0: result negative, neg=1, go to FIX.
- FIX: ten's-complement of r, digit-serial, DIGITS cycles.
  - Initial c=1; t = (9−r_i) + c, with the same >9 correction. This yields the magnitude.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, busy=1 in this cycle; then IDLE with busy=0.
- Latency from the start-sampling edge to done high:
  - normal: DIGITS+1 cycles
  - negative subtraction: 2*DIGITS+1 cycles
  - error: 1 cycle
- Output holding:
  - result, carry, neg and err hold until the next accepted start.
  - All four are cleared at acceptance and reflect the new operation only when done is high.
  - result is written digit-by-digit during CALC/FIX and is undefined for consumers until done.
- start while busy is ignored; start in the same cycle as done is ignored. Acceptance requires IDLE.
- Boundary values:
  - Equal operands on sub: result 0, neg=0 (never "−0").
  - 0−0 gives 0, neg=0.
  - All-9s + all-9s gives 9…98 with carry=1.
- carry is always 0 for subtraction; neg is always 0 for addition.

Optional Feature:
- Macro: BCD_ADDSUB_ACCUM_EN.
- When defined:
  - Adds input acc_sel (1 bit), sampled with start.
  - acc_sel=1 uses the stored result magnitude as operand A instead of port a, for chained calculation. The sign is ignored.
  - An error result (result=0) is used as 0.
- When undefined:
  - The acc_sel port does not exist.
  - Operand A always comes from port a.
  - Behaviour is otherwise identical.

Decomposition:
- Package bcd_addsub_pkg contains:
  - DIGIT_W=4 and BCD_MAX=9
  - the state enum (IDLE, CALC, FIX, DONE)
  - function is_bcd_digit
- Sub-module bcd_digit_addsub: combinational single-digit cell.
  - Inputs: x[3:0], y[3:0], cin, inv.
  - Function: inv selects 9−y.
  - Outputs: s[3:0], cout.
  - Shared by CALC and FIX via operand muxing.

Test Plan (DIGITS=2 unless noted):
- add 27+35, sub_sel=0 -> done 3 cycles after start; result=0x62, carry=0, neg=0, err=0.
- add 99+01 -> result=0x00, carry=1.
- sub 42−17 -> result=0x25, neg=0, done at 3 cycles.
- sub 17−42 -> result=0x25, neg=1, done at 5 cycles; busy high throughout.
- Invalid digit: a=0x1A -> done 1 cycle later; err=1, result=0. Also: start pulsed while busy is ignored; the first result is unchanged.
- Reset: assert rst_n=0 during CALC of 0x55+0x55 -> all outputs 0 and no done. A restart after reset yields 0x10, carry=1.
- With BCD_ADDSUB_ACCUM_EN: 27+35 gives 0x62. Then start with acc_sel=1, b=0x08, add -> result=0x70.
